// File: rtl/slice_pkg.sv
// Shared constants and helpers for the slice carry-chain primitives.
// Latency: none (package only).
// Backpressure: none (package only).
package slice_pkg;

  // Bits handled by one carry-chain primitive.
  localparam int CARRY_W = 4;

  // Number of CARRY4 instances needed to cover a datapath of the given width.
  function automatic int nibbles(input int width);
    return width / CARRY_W;
  endfunction

  // A width is legal when it is a whole, non-zero number of nibbles.
  function automatic bit width_ok(input int width);
    return (width >= CARRY_W) && ((width % CARRY_W) == 0);
  endfunction

endpackage

// File: rtl/CARRY4.sv
// Behavioural model of the 4-bit slice carry chain (mux-carry + xor-sum).
// Latency: purely combinational.
// Backpressure: none.
// Ports: CI/CYINIT carry-in sources, DI generate inputs, S propagate inputs,
//        O sum outputs, CO per-bit carry outputs.
module CARRY4 (
  input  logic       CI,
  input  logic       CYINIT,
  input  logic [3:0] DI,
  input  logic [3:0] S,
  output logic [3:0] O,
  output logic [3:0] CO
);

  logic c;

  // Ripple through the four mux stages: a propagating bit passes the incoming
  // carry, otherwise DI is the carry (generate/kill).
  always_comb begin
    O  = '0;
    CO = '0;
    c  = CI | CYINIT;
    for (int i = 0; i < 4; i++) begin
      O[i]  = S[i] ^ c;
      CO[i] = S[i] ? c : DI[i];
      c     = CO[i];
    end
  end

endmodule

// File: rtl/slice_accum_reg.sv
// Registered add/subtract accumulator built on a chain of CARRY4 primitives.
// Latency: one cycle from an accepted update (CE=1 or R=1) to Q/CO/OVF/ZERO/VLD.
// Backpressure: none; every CE=1 cycle is accepted, back-to-back is legal.
// Ports: C clock, R sync reset (highest priority), CE enable, LOAD parallel
//        load of D, INC/SUB arithmetic operand and direction; outputs Q, CO
//        (carry / no-borrow), OVF (signed overflow), ZERO (Q==0), VLD (update).
module slice_accum_reg
  import slice_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] SRVAL = '0,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             C,
  input  logic             R,
  input  logic             CE,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] INC,
  input  logic             SUB,
  output logic [WIDTH-1:0] Q,
  output logic             CO,
  output logic             OVF,
  output logic             ZERO,
  output logic             VLD
);

  localparam int NIB = nibbles(WIDTH);

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("slice_accum_reg: WIDTH must be a non-zero multiple of 4");
  end

  // Power-up values model the slice flip-flop INIT attribute.
  logic [WIDTH-1:0] q_r    = INIT;
  logic             co_r   = 1'b0;
  logic             ovf_r  = 1'b0;
  logic             zero_r = (INIT == '0);
  logic             vld_r  = 1'b0;

  logic [WIDTH-1:0] b_op;
  logic [WIDTH-1:0] s_vec;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             carry_msb_in;
  logic             ovf_next;

  // Subtraction is Q + ~INC + 1; the +1 enters through CYINIT of nibble 0.
  assign b_op  = SUB ? ~INC : INC;
  assign s_vec = q_r ^ b_op;

  for (genvar k = 0; k < NIB; k++) begin : g_nib
    logic [3:0] o;
    logic [3:0] co;
    logic       ci;
    logic       cyinit;
    logic       unused_co;

    if (k == 0) begin : g_first
      assign ci     = 1'b0;
      assign cyinit = SUB;
    end else begin : g_rest
      assign ci     = g_nib[k-1].co[3];
      assign cyinit = 1'b0;
    end

    CARRY4 u_carry4 (
      .CI     (ci),
      .CYINIT (cyinit),
      .DI     (q_r[4*k +: 4]),
      .S      (s_vec[4*k +: 4]),
      .O      (o),
      .CO     (co)
    );

    assign sum[4*k +: 4] = o;
    // Only CO[3] (and CO[2] of the top nibble) leave the chain.
    assign unused_co = ^co;
  end

  assign carry_out    = g_nib[NIB-1].co[3];
  assign carry_msb_in = g_nib[NIB-1].co[2];
  assign ovf_next     = carry_msb_in ^ carry_out;

  always_ff @(posedge C) begin
    if (R) begin
      q_r    <= SRVAL;
      co_r   <= 1'b0;
      ovf_r  <= 1'b0;
      zero_r <= (SRVAL == '0);
      vld_r  <= 1'b0;
    end else if (CE) begin
      vld_r <= 1'b1;
      if (LOAD) begin
        q_r    <= D;
        co_r   <= 1'b0;
        ovf_r  <= 1'b0;
        zero_r <= (D == '0);
      end else begin
        q_r    <= sum;
        co_r   <= carry_out;
        ovf_r  <= ovf_next;
        zero_r <= (sum == '0);
      end
    end else begin
      vld_r <= 1'b0;
    end
  end

  assign Q    = q_r;
  assign CO   = co_r;
  assign OVF  = ovf_r;
  assign ZERO = zero_r;
  assign VLD  = vld_r;

endmodule

// File: tb/tb_slice_accum_reg.sv
// Directed and random checks of slice_accum_reg (WIDTH=16, SRVAL=0, INIT=0).
// Latency: results sampled 1 time unit after the rising edge that captures them.
// Backpressure: none in the DUT; the bench drives one update per cycle.
module tb_slice_accum_reg;

  logic        clk = 1'b0;
  logic        r, ce, load, sub;
  logic [15:0] d, inc;
  logic [15:0] q;
  logic        co, ovf, zero, vld;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state for the random phase.
  logic [15:0] m_q;
  logic        m_co, m_ovf, m_zero, m_vld;
  logic [16:0] full;

  always #5 clk = ~clk;

  slice_accum_reg #(
    .WIDTH (16),
    .SRVAL (16'h0000),
    .INIT  (16'h0000)
  ) dut (
    .C    (clk),
    .R    (r),
    .CE   (ce),
    .LOAD (load),
    .D    (d),
    .INC  (inc),
    .SUB  (sub),
    .Q    (q),
    .CO   (co),
    .OVF  (ovf),
    .ZERO (zero),
    .VLD  (vld)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag, input logic [15:0] eq, input logic eco,
                           input logic eovf, input logic ezero, input logic evld);
    chk({tag, ".q"},    q,    eq);
    chk({tag, ".co"},   co,   eco);
    chk({tag, ".ovf"},  ovf,  eovf);
    chk({tag, ".zero"}, zero, ezero);
    chk({tag, ".vld"},  vld,  evld);
  endtask

  task automatic drive(input logic ir, input logic ice, input logic iload,
                       input logic [15:0] id, input logic [15:0] iinc, input logic isub);
    r = ir; ce = ice; load = iload; d = id; inc = iinc; sub = isub;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_val(input logic [15:0] v);
    drive(1'b0, 1'b1, 1'b1, v, 16'h0, 1'b0);
    tick();
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    #1;
    check_all("powerup", 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);

    drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    tick();
    check_all("reset", 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);

    drive(1'b1, 1'b1, 1'b1, 16'h1234, 16'h0, 1'b0);
    tick();
    check_all("reset_over_load", 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);

    load_val(16'hFFFF);
    check_all("load_ffff", 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 16'h0, 16'h0001, 1'b0);
    tick();
    check_all("wrap_add", 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1);

    load_val(16'h7FFF);
    drive(1'b0, 1'b1, 1'b0, 16'h0, 16'h0001, 1'b0);
    tick();
    check_all("add_ovf", 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);

    load_val(16'h0FFF);
    drive(1'b0, 1'b1, 1'b0, 16'h0, 16'h0001, 1'b0);
    tick();
    check_all("nibble_ripple", 16'h1000, 1'b0, 1'b0, 1'b0, 1'b1);

    load_val(16'h0000);
    drive(1'b0, 1'b1, 1'b0, 16'h0, 16'h0001, 1'b1);
    tick();
    check_all("sub_borrow", 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1);

    load_val(16'h0005);
    drive(1'b0, 1'b1, 1'b0, 16'h0, 16'h0003, 1'b1);
    tick();
    check_all("sub_noborrow", 16'h0002, 1'b1, 1'b0, 1'b0, 1'b1);

    load_val(16'h8000);
    drive(1'b0, 1'b1, 1'b0, 16'h0, 16'h0001, 1'b1);
    tick();
    check_all("sub_ovf", 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b1);

    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h1111 * (i + 1), i[0]);
      tick();
      check_all("ce_hold", 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0);
    end

    drive(1'b0, 1'b1, 1'b0, 16'h0, 16'h0000, 1'b1);
    tick();
    check_all("sub_zero", 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b1);

    drive(1'b0, 1'b1, 1'b0, 16'h0, 16'h0010, 1'b0);
    tick();
    check_all("b2b_1", 16'h800F, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    check_all("b2b_2", 16'h801F, 1'b0, 1'b0, 1'b0, 1'b1);

    drive(1'b1, 1'b1, 1'b0, 16'h0, 16'h0005, 1'b0);
    tick();
    check_all("reset_midstream", 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);

    // Random phase: the model starts from the reset state just checked.
    m_q = 16'h0; m_co = 1'b0; m_ovf = 1'b0; m_zero = 1'b1; m_vld = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      r    = ($urandom_range(0, 15) == 0);
      ce   = ($urandom_range(0, 3) != 0);
      load = ($urandom_range(0, 4) == 0);
      sub  = $urandom_range(0, 1) == 1;
      d    = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      case ($urandom_range(0, 5))
        0:       inc = 16'h0000;
        1:       inc = 16'h0001;
        2:       inc = 16'hFFFF;
        3:       inc = 16'h8000;
        default: inc = 16'($urandom);
      endcase

      if (r) begin
        m_q = 16'h0; m_co = 1'b0; m_ovf = 1'b0; m_zero = 1'b1; m_vld = 1'b0;
      end else if (ce) begin
        m_vld = 1'b1;
        if (load) begin
          m_q = d; m_co = 1'b0; m_ovf = 1'b0; m_zero = (d == 16'h0);
        end else begin
          if (sub) begin
            full  = {1'b0, m_q} + {1'b0, ~inc} + 17'd1;
            m_ovf = (m_q[15] != inc[15]) && (full[15] != m_q[15]);
          end else begin
            full  = {1'b0, m_q} + {1'b0, inc};
            m_ovf = (m_q[15] == inc[15]) && (full[15] != m_q[15]);
          end
          m_q    = full[15:0];
          m_co   = full[16];
          m_zero = (full[15:0] == 16'h0);
        end
      end else begin
        m_vld = 1'b0;
      end

      tick();
      check_all("rand", m_q, m_co, m_ovf, m_zero, m_vld);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
